// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared constants and types for the multi-cycle MIPS control path
//
// Purpose: opcode values, ALU operation codes, mux-select encodings and the
// main-FSM state encoding. The same package is used by ALUControl and the datapath.
// Ports: none (package).

package mips_ctrl_pkg;

  localparam int CTRL_STATE_W = 4;

  // IR[31:26] values recognised by the main controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // alu_op encoding consumed by ALUControl
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alu_src_b select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // alu_src_a select
  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_A  = 1'b1;

  // pc_source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // memory address select
  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  typedef enum logic [CTRL_STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12
  } state_e;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM of the multi-cycle MIPS datapath
//
// Purpose: sequences fetch/decode/execute/memory/writeback per opcode and
// drives the datapath mux selects, write enables and alu_op.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   opcode           IR[31:26], consulted in DECODE only
//   zero             ALU zero flag (branch gating happens in the datapath)
//   mem_ready        memory completes the current access this cycle
//   pc_write .. pc_source   datapath controls (Moore, plus FETCH ready gating)
//   illegal_op       pulse in DECODE when the opcode is unsupported
//   state_dbg        current state encoding

module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit WAIT_MEM = 1'b1,
  parameter int STATE_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic       rdy;

  // Branch resolution uses zero inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  assign rdy = mem_ready | ~WAIT_MEM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state logic. The opcode is captured in DECODE so that later states
  // follow the decoded path even if IR's upper bits change underneath.
  always_comb begin
    state_d  = S_IDLE;
    opcode_d = opcode_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = rdy ? S_FETCH : S_MEM_WR;
      S_EXEC:     state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ADDI_WB:  state_d = S_FETCH;
      default:    state_d = S_IDLE;   // unused encodings recover via IDLE
    endcase
  end

  // Output decode: everything defaults to 0, each state raises only its own set.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = IORD_PC;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC load only on the cycle the instruction word arrives
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        illegal_op = ~op_supported(opcode);
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = IORD_ALUOUT;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = IORD_ALUOUT;
      end
      S_EXEC: begin
        alu_src_a = SRCA_A;
        alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = SRCA_A;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_ADDI_EX: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg = STATE_W'(state_q);

endmodule
